result_compiler: RTL and testbench
==================================

# result_compiler

Result-mode post-processing stage downstream of the vote logger. On request it snapshots the four 8-bit candidate tallies and scans them sequentially, one candidate per cycle. It then reports the winner index, winner count, total turnout and a tie flag, with a start/done handshake. It feeds the result display path and is active only in result mode (`mode == 1`).

## Interface
Parameters:
- `CAND_W`, 8: width of each candidate tally.
- `TOT_W`, 10: width of the total; must be ≥ `CAND_W + 2`.

Ports:
- `clock`, in, 1: single clock; all logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `mode`, in, 1: 0 = voting, 1 = result; from the same source as the vote logger.
- `start`, in, 1: compile request; level-sampled.
- `cand1_vote` … `cand4_vote`, in, `CAND_W` each: tallies from the vote logger.
- `busy`, out, 1: high while scanning.
- `done`, out, 1: single-cycle pulse when a result is published.
- `result_valid`, out, 1: level; published result outputs are meaningful.
- `winner_id`, out, 3: 0 = no votes; 1..4 = candidate number.
- `winner_votes`, out, `CAND_W`: winner's tally.
- `total_votes`, out, `TOT_W`: sum of all four tallies.
- `tie`, out, 1: another candidate equals the winner's nonzero tally.

## Operation
- FSM states: IDLE, SCAN, DONE.
- **IDLE → SCAN** when `start && mode`:
  - capture all four tallies into a snapshot;
  - clear `idx` to 0, leader count to 0, leader id to 0, accumulator to 0, tie to 0;
  - drop `result_valid`.
- **SCAN**: each cycle processes `snap[idx]`:
  - `acc += snap[idx]`, with zero-extension to `TOT_W`;
  - if `snap[idx] > lead_cnt`: set leader = `idx+1`, `lead_cnt = snap[idx]`, clear tie;
  - else if `snap[idx] == lead_cnt` and `lead_cnt != 0`: set tie.
  - `idx` increments. After `idx == 3` is processed, go to DONE.
- **Entering DONE**: register `winner_id`, `winner_votes`, `total_votes`, `tie` from the final accumulators (including the idx-3 contribution). Pulse `done` and set `result_valid`.
- **DONE**:
  - hold the outputs;
  - `start && mode` re-arms exactly as from IDLE, snapshotting fresh tallies.
- **Mode abort**: `mode == 0` in any state goes to IDLE at the next edge and clears `result_valid`. No `done` is produced; result outputs keep their last values and are invalid.
- Arithmetic rules:
  - ties resolve to the lowest candidate number;
  - all-zero tallies give `winner_id = 0`, `winner_votes = 0`, `tie = 0`, `total_votes = 0`;
  - no overflow is possible (max 4×255 = 1020 < 1024).
- `start` during SCAN is ignored; no queuing.
- The snapshot isolates the scan from tally changes. Tallies are stable in result mode anyway.

## Timing
- Reset values: state IDLE, and `busy`, `done`, `result_valid`, `winner_id`, `winner_votes`, `total_votes`, `tie` all 0.
- Let `start` be sampled in cycle T:
  - `busy` is high in T+1..T+4;
  - `done` and `result_valid` rise in T+5;
  - `done` is low again in T+6.
- Fixed latency: 5 cycles from the `start` cycle to `done`, independent of the data.
- `result_valid` stays high until the next accepted `start` (it is low from T'+1), `mode` falls, or reset.
- Reset mid-scan: IDLE on the next edge; no `done`.
- `start` held high continuously in result mode re-triggers each time DONE is reached. `done` then pulses every 5 cycles.

## Structure
- Shared package holds:
  - `NUM_CAND = 4`;
  - the state enum {IDLE, SCAN, DONE};
  - `WINNER_NONE = 3'd0`.
- The package is reused by the display driver that consumes `winner_id`.
- One natural sub-module: `leader_update`. It is combinational and computes next leader id/count/tie from the current leader and one tally. The top holds the FSM, snapshot and accumulators.

## Test plan
- Reset, then `mode=1`, tallies 3/7/2/5, `start` one cycle → `busy` for 4 cycles, `done` in T+5; expect `winner_id=2`, `winner_votes=7`, `total_votes=17`, `tie=0`.
- Tallies 4/9/9/1 → `winner_id=2`, `winner_votes=9`, `tie=1`, `total=23`. Then tallies 4/9/10/1 with a re-`start` from DONE → `winner_id=3`, `tie=0`.
- All tallies 0 → `winner_id=0`, `winner_votes=0`, `tie=0`, `total=0`, `result_valid=1`.
- Tallies 255×4 → `winner_id=1`, `tie=1`, `total_votes=1020`.
- `mode` falls at T+2 → no `done` pulse, `result_valid=0`, state IDLE. Also: `start` with `mode=0` → no response.
- Reset asserted at T+3 → all outputs 0 next cycle. Extra `start` pulses at T+2 → ignored, still exactly one `done` at T+5.

Source files
------------

// File: rtl/result_compiler_pkg.sv
// Shared result-mode definitions: candidate count, compiler FSM states and
// the "no winner" code, also consumed by the display driver decoding winner_id.
package result_compiler_pkg;

  localparam int NUM_CAND = 4;
  localparam int IDX_W    = 2;

  localparam logic [2:0] WINNER_NONE = 3'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/result_compiler_leader_update.sv
// Combinational leader step: folds one candidate tally into the running leader.
// Zero latency; no flow control (pure function of its inputs).
module leader_update #(
  parameter int CAND_W = 8
) (
  input  logic [2:0]        lead_id,
  input  logic [CAND_W-1:0] lead_cnt,
  input  logic              lead_tie,
  input  logic [2:0]        tally_id,
  input  logic [CAND_W-1:0] tally,
  output logic [2:0]        next_id,
  output logic [CAND_W-1:0] next_cnt,
  output logic              next_tie
);

  always_comb begin
    next_id  = lead_id;
    next_cnt = lead_cnt;
    next_tie = lead_tie;
    // Strict greater-than keeps the earliest (lowest-numbered) candidate on a tie.
    if (tally > lead_cnt) begin
      next_id  = tally_id;
      next_cnt = tally;
      next_tie = 1'b0;
    end else if ((tally == lead_cnt) && (lead_cnt != '0)) begin
      next_tie = 1'b1;
    end
  end

endmodule

// File: rtl/result_compiler.sv
// Snapshots four tallies on start and scans one per cycle; done pulses 5 cycles after start.
// start is ignored while scanning (no queuing); mode low aborts to IDLE and invalidates results.
module result_compiler
  import result_compiler_pkg::*;
#(
  parameter int CAND_W = 8,
  parameter int TOT_W  = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mode,
  input  logic              start,
  input  logic [CAND_W-1:0] cand1_vote,
  input  logic [CAND_W-1:0] cand2_vote,
  input  logic [CAND_W-1:0] cand3_vote,
  input  logic [CAND_W-1:0] cand4_vote,
  output logic              busy,
  output logic              done,
  output logic              result_valid,
  output logic [2:0]        winner_id,
  output logic [CAND_W-1:0] winner_votes,
  output logic [TOT_W-1:0]  total_votes,
  output logic              tie
);

  state_t state, state_nxt;

  logic [CAND_W-1:0] snap [NUM_CAND];
  logic [IDX_W-1:0]  idx;
  logic [2:0]        lead_id;
  logic [CAND_W-1:0] lead_cnt;
  logic              lead_tie;
  logic [TOT_W-1:0]  acc;

  logic [CAND_W-1:0] cur;
  logic [TOT_W-1:0]  acc_nxt;
  logic [2:0]        lead_id_nxt;
  logic [CAND_W-1:0] lead_cnt_nxt;
  logic              lead_tie_nxt;
  logic              last;

  assign cur     = snap[idx];
  assign acc_nxt = acc + {{(TOT_W-CAND_W){1'b0}}, cur};
  assign last    = (idx == IDX_W'(NUM_CAND - 1));
  assign busy    = (state == SCAN);

  leader_update #(.CAND_W(CAND_W)) u_leader_update (
    .lead_id  (lead_id),
    .lead_cnt (lead_cnt),
    .lead_tie (lead_tie),
    .tally_id ({1'b0, idx} + 3'd1),
    .tally    (cur),
    .next_id  (lead_id_nxt),
    .next_cnt (lead_cnt_nxt),
    .next_tie (lead_tie_nxt)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!mode) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = SCAN;
        SCAN:    if (last)  state_nxt = DONE;
        DONE:    if (start) state_nxt = SCAN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CAND; i++) snap[i] <= '0;
      idx          <= '0;
      lead_id      <= WINNER_NONE;
      lead_cnt     <= '0;
      lead_tie     <= 1'b0;
      acc          <= '0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      winner_id    <= WINNER_NONE;
      winner_votes <= '0;
      total_votes  <= '0;
      tie          <= 1'b0;
    end else if (!mode) begin
      // Published values are kept for inspection but flagged invalid.
      done         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            snap[0]      <= cand1_vote;
            snap[1]      <= cand2_vote;
            snap[2]      <= cand3_vote;
            snap[3]      <= cand4_vote;
            idx          <= '0;
            lead_id      <= WINNER_NONE;
            lead_cnt     <= '0;
            lead_tie     <= 1'b0;
            acc          <= '0;
            result_valid <= 1'b0;
          end
        end
        SCAN: begin
          acc      <= acc_nxt;
          lead_id  <= lead_id_nxt;
          lead_cnt <= lead_cnt_nxt;
          lead_tie <= lead_tie_nxt;
          idx      <= idx + IDX_W'(1);
          if (last) begin
            winner_id    <= lead_id_nxt;
            winner_votes <= lead_cnt_nxt;
            total_votes  <= acc_nxt;
            tie          <= lead_tie_nxt;
            done         <= 1'b1;
            result_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_result_compiler.sv
// Directed bench for result_compiler: hand-computed tallies, timing of busy/done,
// aborts, reset mid-scan and start re-triggering.
module tb_result_compiler;

  logic       clock;
  logic       reset;
  logic       mode;
  logic       start;
  logic [7:0] cand1_vote, cand2_vote, cand3_vote, cand4_vote;
  logic       busy, done, result_valid, tie;
  logic [2:0] winner_id;
  logic [7:0] winner_votes;
  logic [9:0] total_votes;

  int total = 0;
  int bad   = 0;

  result_compiler #(.CAND_W(8), .TOT_W(10)) dut (
    .clock        (clock),
    .reset        (reset),
    .mode         (mode),
    .start        (start),
    .cand1_vote   (cand1_vote),
    .cand2_vote   (cand2_vote),
    .cand3_vote   (cand3_vote),
    .cand4_vote   (cand4_vote),
    .busy         (busy),
    .done         (done),
    .result_valid (result_valid),
    .winner_id    (winner_id),
    .winner_votes (winner_votes),
    .total_votes  (total_votes),
    .tie          (tie)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_tallies(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
    cand1_vote = a;
    cand2_vote = b;
    cand3_vote = c;
    cand4_vote = d;
  endtask

  // Starts one compile from IDLE/DONE and checks the full T+1..T+6 timeline.
  task automatic run_compile(input string tag,
                             input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d,
                             input logic [2:0] exp_id, input logic [7:0] exp_votes,
                             input logic [9:0] exp_total, input logic exp_tie);
    set_tallies(a, b, c, d);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, ".valid_drop"}, result_valid, 0);
    for (int i = 0; i < 4; i++) begin
      check({tag, ".busy"}, busy, 1);
      check({tag, ".done_early"}, done, 0);
      tick();
    end
    check({tag, ".done"}, done, 1);
    check({tag, ".valid"}, result_valid, 1);
    check({tag, ".busy_end"}, busy, 0);
    check({tag, ".winner_id"}, winner_id, exp_id);
    check({tag, ".winner_votes"}, winner_votes, exp_votes);
    check({tag, ".total_votes"}, total_votes, exp_total);
    check({tag, ".tie"}, tie, exp_tie);
    tick();
    check({tag, ".done_pulse"}, done, 0);
    check({tag, ".valid_hold"}, result_valid, 1);
  endtask

  initial begin
    reset = 1'b1;
    mode  = 1'b0;
    start = 1'b0;
    set_tallies(8'd0, 8'd0, 8'd0, 8'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.valid", result_valid, 0);
    check("rst.winner_id", winner_id, 0);
    check("rst.winner_votes", winner_votes, 0);
    check("rst.total", total_votes, 0);
    check("rst.tie", tie, 0);

    mode = 1'b1;
    run_compile("basic", 8'd3, 8'd7, 8'd2, 8'd5, 3'd2, 8'd7, 10'd17, 1'b0);
    run_compile("tie", 8'd4, 8'd9, 8'd9, 8'd1, 3'd2, 8'd9, 10'd23, 1'b1);
    run_compile("restart", 8'd4, 8'd9, 8'd10, 8'd1, 3'd3, 8'd10, 10'd24, 1'b0);
    run_compile("zero", 8'd0, 8'd0, 8'd0, 8'd0, 3'd0, 8'd0, 10'd0, 1'b0);
    run_compile("max", 8'd255, 8'd255, 8'd255, 8'd255, 3'd1, 8'd255, 10'd1020, 1'b1);

    // mode falls in T+2: scan aborts, no done, results kept but invalid
    set_tallies(8'd1, 8'd1, 8'd1, 8'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    mode = 1'b0;
    tick();
    check("abort.busy", busy, 0);
    check("abort.valid", result_valid, 0);
    for (int i = 0; i < 4; i++) begin
      check("abort.no_done", done, 0);
      tick();
    end
    check("abort.winner_kept", winner_id, 1);
    check("abort.total_kept", total_votes, 1020);

    // start while in voting mode has no effect
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mode0.busy", busy, 0);
      check("mode0.done", done, 0);
      check("mode0.valid", result_valid, 0);
    end
    start = 1'b0;

    // reset asserted during T+3
    mode = 1'b1;
    set_tallies(8'd9, 8'd8, 8'd7, 8'd6);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("rstmid.busy_before", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid.busy", busy, 0);
    check("rstmid.valid", result_valid, 0);
    check("rstmid.winner_id", winner_id, 0);
    check("rstmid.winner_votes", winner_votes, 0);
    check("rstmid.total", total_votes, 0);
    check("rstmid.tie", tie, 0);
    for (int i = 0; i < 4; i++) begin
      check("rstmid.no_done", done, 0);
      tick();
    end

    // extra start during SCAN is ignored: exactly one done at T+5
    set_tallies(8'd1, 8'd2, 8'd3, 8'd4);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ign.done_t3", done, 0);
    tick();
    check("ign.done_t4", done, 0);
    tick();
    check("ign.done_t5", done, 1);
    check("ign.winner_id", winner_id, 4);
    check("ign.total", total_votes, 10);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ign.single_done", done, 0);
      check("ign.no_busy", busy, 0);
    end

    // start held high: done every 5 cycles
    set_tallies(8'd5, 8'd0, 8'd0, 8'd6);
    start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("held.done", done, (i % 5 == 0) ? 1 : 0);
    end
    start = 1'b0;
    check("held.winner_id", winner_id, 4);
    check("held.total", total_votes, 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
